// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, access sizes,
// memory write codes and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsuState_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_WORD = 2'b01;

    // Size 2'b11 has no legal encoding, so it is reported the same way as a bad offset.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: isMisaligned = 1'b0;
            SZ_HALF: isMisaligned = off[0];
            SZ_WORD: isMisaligned = (off != 2'b00);
            default: isMisaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering shared by both paths: extracts and extends a load lane, and
// merges store data into the word read back for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        unsigned_i,
    output logic [31:0] loadData_o,
    output logic [31:0] storeWord_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        case (off_i)
            2'd0:    byteLane = word_i[7:0];
            2'd1:    byteLane = word_i[15:8];
            2'd2:    byteLane = word_i[23:16];
            default: byteLane = word_i[31:24];
        endcase
        halfLane = off_i[1] ? word_i[31:16] : word_i[15:0];

        loadData_o  = word_i;
        storeWord_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                loadData_o = unsigned_i ? {24'h0, byteLane} : {{24{byteLane[7]}}, byteLane};
                case (off_i)
                    2'd0:    storeWord_o[7:0]   = wdata_i[7:0];
                    2'd1:    storeWord_o[15:8]  = wdata_i[7:0];
                    2'd2:    storeWord_o[23:16] = wdata_i[7:0];
                    default: storeWord_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                loadData_o = unsigned_i ? {16'h0, halfLane} : {{16{halfLane[15]}}, halfLane};
                if (off_i[1]) storeWord_o[31:16] = wdata_i;
                else          storeWord_o[15:0]  = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: one request at a time, sub-word stores done as
// read-modify-write so lane placement never depends on the memory's partial writes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_misalign,
    output logic [31:0]       mem_address,
    output logic [31:0]       mem_dataIn,
    output logic [1:0]        mem_memWrite,
    output logic              mem_memRead,
    input  logic [31:0]       mem_data
);

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    lsuState_e   state_q;
    logic [3:0]  cnt_q;
    logic        store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic        respValid_q;
    logic [31:0] respRdata_q;
    logic        respMisalign_q;
    logic [31:0] memAddress_q;
    logic [31:0] memDataIn_q;
    logic [1:0]  memWrite_q;
    logic        memRead_q;

    logic [ADDR_W-1:0] wordIndex;
    logic [31:0]       loadData;
    logic [31:0]       mergedWord;

    assign wordIndex = req_addr >> 2;

    // The lane unit always looks at the live memory return; its result is only
    // captured on the final READ cycle.
    lsu_lane_align u_align (
        .word_i      (mem_data),
        .wdata_i     (wdata_q),
        .size_i      (size_q),
        .off_i       (off_q),
        .unsigned_i  (unsigned_q),
        .loadData_o  (loadData),
        .storeWord_o (mergedWord)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            store_q        <= 1'b0;
            size_q         <= SZ_BYTE;
            unsigned_q     <= 1'b0;
            off_q          <= 2'b00;
            wdata_q        <= 16'h0;
            respValid_q    <= 1'b0;
            respRdata_q    <= 32'h0;
            respMisalign_q <= 1'b0;
            memAddress_q   <= 32'h0;
            memDataIn_q    <= 32'h0;
            memWrite_q     <= MW_NONE;
            memRead_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    respValid_q <= 1'b0;
                    if (req_valid) begin
                        store_q      <= req_store;
                        size_q       <= req_size;
                        unsigned_q   <= req_unsigned;
                        off_q        <= req_addr[1:0];
                        wdata_q      <= req_wdata[15:0];
                        memAddress_q <= 32'(wordIndex);
                        if (isMisaligned(req_size, req_addr[1:0])) begin
                            respValid_q    <= 1'b1;
                            respMisalign_q <= 1'b1;
                            respRdata_q    <= 32'h0;
                            state_q        <= RESP;
                        end else if (req_store && req_size == SZ_WORD) begin
                            memDataIn_q <= req_wdata;
                            memWrite_q  <= MW_WORD;
                            state_q     <= WRITE;
                        end else begin
                            memRead_q <= 1'b1;
                            cnt_q     <= 4'd0;
                            state_q   <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt_q == LAST_CNT) begin
                        memRead_q <= 1'b0;
                        if (store_q) begin
                            memDataIn_q <= mergedWord;
                            memWrite_q  <= MW_WORD;
                            state_q     <= WRITE;
                        end else begin
                            respRdata_q    <= loadData;
                            respMisalign_q <= 1'b0;
                            respValid_q    <= 1'b1;
                            state_q        <= RESP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                WRITE: begin
                    memWrite_q     <= MW_NONE;
                    respRdata_q    <= 32'h0;
                    respMisalign_q <= 1'b0;
                    respValid_q    <= 1'b1;
                    state_q        <= RESP;
                end
                RESP: begin
                    respValid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign resp_valid    = respValid_q;
    assign resp_rdata    = respRdata_q;
    assign resp_misalign = respMisalign_q;
    assign mem_address   = memAddress_q;
    assign mem_dataIn    = memDataIn_q;
    assign mem_memWrite  = memWrite_q;
    assign mem_memRead   = memRead_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one instance at MEM_LATENCY=1, one at 3,
// each with a small word memory modelled in the bench.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        reqStore;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic        reqValid1, reqValid3;

    logic        ready1, rv1, mis1, mr1;
    logic [31:0] rdata1, addr1, din1, memData1;
    logic [1:0]  mw1;
    logic        ready3, rv3, mis3, mr3;
    logic [31:0] rdata3, addr3, din3, memData3;
    logic [1:0]  mw3;

    logic [31:0] mem1 [16];
    logic [31:0] mem3 [16];

    assign memData1 = mem1[addr1[3:0]];
    assign memData3 = mem3[addr3[3:0]];

    load_store_unit #(.MEM_LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset(reset), .req_valid(reqValid1), .req_ready(ready1),
        .req_store(reqStore), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .resp_valid(rv1),
        .resp_rdata(rdata1), .resp_misalign(mis1), .mem_address(addr1),
        .mem_dataIn(din1), .mem_memWrite(mw1), .mem_memRead(mr1), .mem_data(memData1)
    );

    load_store_unit #(.MEM_LATENCY(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset(reset), .req_valid(reqValid3), .req_ready(ready3),
        .req_store(reqStore), .req_size(reqSize), .req_unsigned(reqUnsigned),
        .req_addr(reqAddr), .req_wdata(reqWdata), .resp_valid(rv3),
        .resp_rdata(rdata3), .resp_misalign(mis3), .mem_address(addr3),
        .mem_dataIn(din3), .mem_memWrite(mw3), .mem_memRead(mr3), .mem_data(memData3)
    );

    // Selects which instance the request task drives and observes.
    logic        sel;
    logic        sReady, sRv, sMis, sMr;
    logic [31:0] sRdata, sAddr, sDin;
    logic [1:0]  sMw;
    assign sReady = sel ? ready3 : ready1;
    assign sRv    = sel ? rv3    : rv1;
    assign sMis   = sel ? mis3   : mis1;
    assign sMr    = sel ? mr3    : mr1;
    assign sRdata = sel ? rdata3 : rdata1;
    assign sAddr  = sel ? addr3  : addr1;
    assign sDin   = sel ? din3   : din1;
    assign sMw    = sel ? mw3    : mw1;

    int total = 0;
    int bad   = 0;
    int overlap = 0;

    int          respCycle, reads, writes, readyLow;
    logic [31:0] rdata, lastDin, lastAddr;
    logic        mis, postIdle;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Issues one request at a negedge and watches it until resp_valid, applying
    // memory writes to the model as they appear. Cycle k is the k-th negedge after accept.
    task automatic applyStimulus(input logic which, input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd);
        sel = which;
        reqStore = st; reqSize = sz; reqUnsigned = uns; reqAddr = a; reqWdata = wd;
        if (which) reqValid3 = 1'b1; else reqValid1 = 1'b1;
        respCycle = -1; reads = 0; writes = 0; readyLow = 0;
        rdata = 32'hx; mis = 1'bx; lastDin = 32'h0; lastAddr = 32'hx;
        @(posedge clk);
        #1 reqValid1 = 1'b0; reqValid3 = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (sMr) begin reads++; lastAddr = sAddr; end
            if (sMw != 2'b00) begin
                writes++;
                lastDin = sDin;
                lastAddr = sAddr;
                if (sMw == 2'b01) begin
                    if (which) mem3[sAddr[3:0]] = sDin; else mem1[sAddr[3:0]] = sDin;
                end
            end
            if (sMr && sMw != 2'b00) overlap++;
            if (!sReady) readyLow++;
            if (sRv) begin
                respCycle = k; rdata = sRdata; mis = sMis;
                break;
            end
        end
        @(negedge clk);
        postIdle = sReady && !sRv;
    endtask

    initial begin
        reset = 1'b1; reqValid1 = 1'b0; reqValid3 = 1'b0; sel = 1'b0;
        reqStore = 1'b0; reqSize = 2'b00; reqUnsigned = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
        for (int i = 0; i < 16; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
        mem1[5] = 32'hDEADBEEF; mem1[2] = 32'h1280FF7F; mem1[3] = 32'h11223344;
        mem3[8] = 32'h80010000; mem3[7] = 32'hAAAABBBB;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready", {31'h0, ready1}, 32'd1);
        checkOutput("reset outs", {rv1, mis1, mr1, mw1, rv3, mr3, mw3}, 32'h0);
        checkOutput("reset rdata", rdata1, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] word load, latency 1");
        applyStimulus(1'b0, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        checkOutput("wload cycle", respCycle, 32'd2);
        checkOutput("wload rdata", rdata, 32'hDEADBEEF);
        checkOutput("wload addr", lastAddr, 32'd5);
        checkOutput("wload reads", reads, 32'd1);
        checkOutput("wload readyLow", readyLow, 32'd2);
        checkOutput("wload post idle", {31'h0, postIdle}, 32'd1);

        $display("[TB] byte loads signed/unsigned");
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0A, 32'h0);
        checkOutput("bload s rdata", rdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b1, 32'h0A, 32'h0);
        checkOutput("bload u rdata", rdata, 32'h00000080);
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0B, 32'h0);
        checkOutput("bload lane3", rdata, 32'h00000012);
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b1, 32'h08, 32'h0);
        checkOutput("hload u lane0", rdata, 32'h0000FF7F);

        $display("[TB] byte store read-modify-write");
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 32'h0D, 32'h000000AB);
        checkOutput("bstore cycle", respCycle, 32'd3);
        checkOutput("bstore reads", reads, 32'd1);
        checkOutput("bstore writes", writes, 32'd1);
        checkOutput("bstore dataIn", lastDin, 32'h1122AB44);
        checkOutput("bstore misalign", {31'h0, mis}, 32'd0);
        checkOutput("bstore rdata", rdata, 32'h0);
        checkOutput("bstore mem", mem1[3], 32'h1122AB44);

        $display("[TB] word store");
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        checkOutput("wstore cycle", respCycle, 32'd2);
        checkOutput("wstore reads", reads, 32'd0);
        checkOutput("wstore writes", writes, 32'd1);
        checkOutput("wstore mem", mem1[4], 32'h12345678);

        $display("[TB] misaligned requests");
        applyStimulus(1'b0, 1'b0, 2'b01, 1'b0, 32'h0B, 32'h0);
        checkOutput("mis half cycle", respCycle, 32'd1);
        checkOutput("mis half flag", {31'h0, mis}, 32'd1);
        checkOutput("mis half traffic", reads + writes, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF);
        checkOutput("mis size11 flag", {31'h0, mis}, 32'd1);
        checkOutput("mis size11 traffic", reads + writes, 32'd0);

        $display("[TB] latency 3 accesses");
        applyStimulus(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        checkOutput("l3 hload cycle", respCycle, 32'd4);
        checkOutput("l3 hload reads", reads, 32'd3);
        checkOutput("l3 hload rdata", rdata, 32'hFFFF8001);
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h1E, 32'h0000CCDD);
        checkOutput("l3 hstore cycle", respCycle, 32'd5);
        checkOutput("l3 hstore mem", mem3[7], 32'hCCDDBBBB);

        $display("[TB] reset during READ of a byte store");
        mem1[3] = 32'h55667788;
        sel = 1'b0;
        reqStore = 1'b1; reqSize = 2'b00; reqUnsigned = 1'b0; reqAddr = 32'h0D; reqWdata = 32'hEE;
        reqValid1 = 1'b1;
        @(posedge clk);
        #1 reqValid1 = 1'b0;
        checkOutput("rst in READ", {31'h0, mr1}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst ready", {31'h0, ready1}, 32'd1);
        checkOutput("rst outs", {rv1, mr1, mw1}, 32'h0);
        reset = 1'b0;
        writes = 0; respCycle = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mw1 != 2'b00) begin writes++; mem1[addr1[3:0]] = din1; end
            if (rv1) respCycle++;
        end
        checkOutput("rst no write", writes, 32'd0);
        checkOutput("rst no resp", respCycle, 32'd0);
        checkOutput("rst mem kept", mem1[3], 32'h55667788);

        checkOutput("rd/wr overlap", overlap, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the word-indexed data memory. Accepts one load/store request from the pipeline and drives the memory port (address, dataIn, memWrite, memRead).
- Loads: captures the returned word, then extracts and sign/zero-extends the addressed lane.
- Sub-word stores: done as read-modify-write, so byte/half placement is correct regardless of the memory's low-lane-only partial writes.
- Holds req_ready low while busy so the pipeline stalls.

Parameters:
- MEM_LATENCY, 1: cycles mem_memRead is held before mem_data is sampled; legal range 1..15.
- ADDR_W, 32: width of the byte address from the pipeline.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_store  in  1  1=store, 0=load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data; the low lane is used for byte/half
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_rdata  out  32  extended load data; 0 for stores
- resp_misalign  out  1  qualified by resp_valid
- mem_address  out  32  word index = req_addr >> 2 (zero-filled)
- mem_dataIn  out  32  write data
- mem_memWrite  out  2  00 idle, 01 full word; 10/11 never driven
- mem_memRead  out  1  read enable
- mem_data  in  32  read data from memory

Behaviour:
- All outputs are registered except req_ready, which is decoded from state.
- Reset (synchronous, active-high): state=IDLE, latency counter=0. All registered outputs are 0 from the edge where reset is sampled high.
- Reset mid-operation: abandon the request. No resp_valid is issued. Any pending write is dropped, and mem_memWrite is 0 from the reset edge.
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. Handshake is req_valid && req_ready at edge T. The unit latches op, address, wdata and lane offset off=req_addr[1:0].
- Misaligned request (half with off[0]=1, word with off!=0, or size 11): go to RESP with resp_misalign=1. No memory traffic.
- Load, or byte/half store: enter READ at T+1 with mem_memRead=1 and mem_address valid.
  - Hold both for MEM_LATENCY cycles, counter counting 0..MEM_LATENCY-1.
  - Sample mem_data on the edge where counter=MEM_LATENCY-1.
  - mem_memRead drops that same edge.
- Load completes to RESP:
  - Byte: lane = word[8*off +: 8].
  - Half: lane = word[16*off[1] +: 16].
  - Word: full word.
  - Extend the lane to 32 bits by req_unsigned.
  - With MEM_LATENCY=1: accept T, READ T+1, resp_valid T+2.
- Sub-word store after READ: go to WRITE with the merged word, i.e. the read word with only the addressed lane replaced by req_wdata's low byte/half.
- Word store: IDLE goes directly to WRITE with mem_dataIn=req_wdata.
- WRITE: mem_memWrite=01 for exactly one cycle with address/dataIn stable, then RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - resp_rdata holds until the next RESP.
  - Back-to-back requests: the earliest next accept is the cycle after RESP.
- mem_memRead and mem_memWrite are never asserted in the same cycle.
- Address wrap: mem_address carries req_addr[ADDR_W-1:2] unmodified. Range checking is the memory's job.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, READ, WRITE, RESP)
  - size localparams SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - memWrite codes MW_NONE=2'b00, MW_WORD=2'b01
- One combinational sub-module lsu_lane_align. It does both load extract/extend and store merge from (word, wdata, size, off, unsigned) and is reused by both paths.
- FSM and counter stay in the top module.

Test Plan:
- Word load, MEM_LATENCY=1, mem[5]=32'hDEADBEEF, addr 0x14 -> mem_address=5, mem_memRead high for 1 cycle, resp_valid at T+2, resp_rdata=32'hDEADBEEF, req_ready low T+1..T+2.
- Byte load signed, mem[2]=32'h1280FF7F, addr 0x0A -> resp_rdata=32'hFFFFFF80. Same request with req_unsigned=1 -> 32'h00000080.
- Byte store RMW, mem[3]=32'h11223344, addr 0x0D, wdata 32'hAB -> one read, then single mem_memWrite=01 pulse with mem_dataIn=32'h1122AB44, resp_misalign=0.
- Misaligned half, addr 0x0B -> no mem_memRead or mem_memWrite ever, resp_valid at T+1 with resp_misalign=1.
- MEM_LATENCY=3 half load, addr 0x22, mem[8]=32'h8001_0000 -> mem_memRead held 3 cycles, resp_rdata=32'hFFFF8001 at T+4.
- Reset asserted during READ of a byte store -> next cycle state IDLE, req_ready=1, no write pulse, no resp_valid; memory word unchanged.
